alu_arbiter: RTL and testbench

Shares one registered 4-bit ALU (opcode set SEL..ROTATE_R, one-cycle result latency, `valid_out` dropped for rejected operations) among NREQ requesters. It arbitrates round-robin, drives the ALU's operand, control and carry-in ports, and keeps a per-requester carry flag register that supplies `cin`. It returns each result on a valid/ready response channel, including an error indication. It sits between the ALU and the client blocks that issue arithmetic operations.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/alu_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   opcode_e     : ALU opcode set SEL..ROTATE_R (14 and 15 are not valid ALU opcodes)
//   state_e      : arbiter control FSM states
//   ALU_W        : ALU operand/result width
//   is_carry_op  : opcodes whose carry-out updates a requester's carry flag
package alu_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [3:0] {
        SEL      = 4'd0,
        INC      = 4'd1,
        DEC      = 4'd2,
        ADD      = 4'd3,
        ADD_c    = 4'd4,
        SUB      = 4'd5,
        SUB_b    = 4'd6,
        AND      = 4'd7,
        OR       = 4'd8,
        XOR      = 4'd9,
        SHIFT_L  = 4'd10,
        SHIFT_R  = 4'd11,
        ROTATE_L = 4'd12,
        ROTATE_R = 4'd13
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    function automatic logic is_carry_op(input logic [ALU_W-1:0] ctl);
        return (ctl == ADD) || (ctl == ADD_c) || (ctl == SUB) || (ctl == SUB_b);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req   : per-requester request vector
//   ptr   : index of the highest-priority requester this round
//   grant : one-hot grant, first requester at or after ptr (modulo NREQ), or 0
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int PW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        // k is the distance from ptr; i is the requester sitting at that distance.
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among NREQ requesters with round-robin arbitration,
// a per-requester carry flag feeding alu_cin, and a valid/ready response channel.
//   req_valid/req_ready/req_a/req_b/req_ctl : request channel (slice i = requester i)
//   rsp_valid/rsp_ready/rsp_alu/rsp_carry/rsp_zero/rsp_err : response channel
//   busy                                    : high whenever the FSM is not IDLE
//   alu_valid_in/alu_a/alu_b/alu_ctl/alu_cin : ALU request side
//   alu_valid_out/alu_result/alu_carry/alu_zero : ALU result side (one-cycle latency)
// Optional build macro ALU_ARB_OPCODE_CHECK_EN: opcodes above ROTATE_R are answered
// with an error directly from IDLE and never reach the ALU.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [ALU_W*NREQ-1:0] req_a,
    input  logic [ALU_W*NREQ-1:0] req_b,
    input  logic [ALU_W*NREQ-1:0] req_ctl,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [ALU_W-1:0]      rsp_alu,
    output logic                  rsp_carry,
    output logic                  rsp_zero,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  alu_valid_in,
    output logic [ALU_W-1:0]      alu_a,
    output logic [ALU_W-1:0]      alu_b,
    output logic [ALU_W-1:0]      alu_ctl,
    output logic                  alu_cin,
    input  logic                  alu_valid_out,
    input  logic [ALU_W-1:0]      alu_result,
    input  logic                  alu_carry,
    input  logic                  alu_zero
);

    localparam int PW = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     idx_q, idx_d;
    logic [ALU_W-1:0]  a_q, a_d, b_q, b_d, ctl_q, ctl_d;
    logic [ALU_W-1:0]  res_q, res_d;
    logic              cry_q, cry_d, zro_q, zro_d, err_q, err_d;
    logic [NREQ-1:0]   flag_q, flag_d;

    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   rsp_sel;
    logic [PW-1:0]     win_idx, win_next;
    logic [ALU_W-1:0]  win_a, win_b, win_ctl;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Decode the one-hot grant into the winner's index, operands and next pointer.
    always_comb begin
        win_idx  = '0;
        win_next = '0;
        win_a    = '0;
        win_b    = '0;
        win_ctl  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_idx  = PW'(i);
                win_next = PW'((i + 1) % NREQ);
                win_a    = req_a[ALU_W*i +: ALU_W];
                win_b    = req_b[ALU_W*i +: ALU_W];
                win_ctl  = req_ctl[ALU_W*i +: ALU_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rsp_sel[i] = (idx_q == PW'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        a_d          = a_q;
        b_d          = b_q;
        ctl_d        = ctl_q;
        res_d        = res_q;
        cry_d        = cry_q;
        zro_d        = zro_q;
        err_d        = err_q;
        flag_d       = flag_q;
        req_ready    = '0;
        rsp_valid    = '0;
        alu_valid_in = 1'b0;
        alu_cin      = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (|grant) begin
                    idx_d   = win_idx;
                    a_d     = win_a;
                    b_d     = win_b;
                    ctl_d   = win_ctl;
                    ptr_d   = win_next;
                    state_d = ISSUE;
`ifdef ALU_ARB_OPCODE_CHECK_EN
                    // Invalid opcodes are answered locally; the ALU never sees them.
                    if (win_ctl > ROTATE_R) begin
                        res_d   = '0;
                        cry_d   = 1'b0;
                        zro_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
`endif
                end
            end
            ISSUE: begin
                alu_valid_in = 1'b1;
                alu_cin      = flag_q[idx_q];
                state_d      = WAIT;
            end
            WAIT: begin
                if (alu_valid_out) begin
                    res_d = alu_result;
                    cry_d = alu_carry;
                    zro_d = alu_zero;
                    err_d = 1'b0;
                    if (is_carry_op(ctl_q)) begin
                        flag_d[idx_q] = alu_carry;
                    end
                end else begin
                    // Rejected by the ALU: report an error with clean flags.
                    res_d = '0;
                    cry_d = 1'b0;
                    zro_d = 1'b0;
                    err_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = rsp_sel;
                if (|(rsp_ready & rsp_sel)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ctl_q   <= '0;
            res_q   <= '0;
            cry_q   <= 1'b0;
            zro_q   <= 1'b0;
            err_q   <= 1'b0;
            flag_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctl_q   <= ctl_d;
            res_q   <= res_d;
            cry_q   <= cry_d;
            zro_q   <= zro_d;
            err_q   <= err_d;
            flag_q  <= flag_d;
        end
    end

    // Operands stay on the ALU bus between issues; only alu_valid_in qualifies them.
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_ctl   = ctl_q;
    assign rsp_alu   = res_q;
    assign rsp_carry = cry_q;
    assign rsp_zero  = zro_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 4;
`ifdef ALU_ARB_OPCODE_CHECK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [W*NREQ-1:0] req_a = '0, req_b = '0, req_ctl = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready = '1;
    logic [W-1:0]      rsp_alu;
    logic              rsp_carry, rsp_zero, rsp_err, busy;
    logic              alu_valid_in;
    logic [W-1:0]      alu_a, alu_b, alu_ctl;
    logic              alu_cin;
    logic              alu_valid_out = 1'b0;
    logic [W-1:0]      alu_result = '0;
    logic              alu_carry = 1'b0, alu_zero = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit rr_mode = 1'b0;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_ctl       (req_ctl),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_alu       (rsp_alu),
        .rsp_carry     (rsp_carry),
        .rsp_zero      (rsp_zero),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .alu_valid_in  (alu_valid_in),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_ctl       (alu_ctl),
        .alu_cin       (alu_cin),
        .alu_valid_out (alu_valid_out),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .alu_zero      (alu_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Arithmetic meaning of each opcode; the ALU stub rejects opcodes 14/15
    // and INC/DEC with b = F.
    function automatic void alu_ref(input logic [3:0] ctl, input logic [3:0] a, input logic [3:0] b,
                                    input logic cin, output logic [3:0] r, output logic c, output logic ok);
        int s;
        ok = 1'b1;
        s  = 0;
        case (int'(ctl))
            0:  s = a;
            1:  begin s = a + 1;       ok = (b != 4'hF); end
            2:  begin s = a - 1;       ok = (b != 4'hF); end
            3:  s = a + b;
            4:  s = a + b + cin;
            5:  s = a - b;
            6:  s = a - b - cin;
            7:  s = a & b;
            8:  s = a | b;
            9:  s = a ^ b;
            10: s = a * 2;
            11: s = (a / 2) + (a[0] ? 16 : 0);
            12: s = ((a * 2) % 16) + (a / 8);
            13: s = (a / 2) + (a[0] ? 8 : 0);
            default: ok = 1'b0;
        endcase
        r = 4'(s % 16);
        c = (s < 0) || (s > 15);
    endfunction

    // Registered ALU stub: one-cycle latency, valid_out dropped on rejection.
    always @(posedge clk) begin
        logic [3:0] r;
        logic c, ok;
        alu_ref(alu_ctl, alu_a, alu_b, alu_cin, r, c, ok);
        alu_valid_out <= alu_valid_in && ok;
        alu_result    <= ok ? r : 4'hA;
        alu_carry     <= ok ? c : 1'b1;
        alu_zero      <= ok ? (r == 4'h0) : 1'b1;
    end

    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (((v >> i) & 1) != 0) return NREQ'(1) << i;
        end
        return '0;
    endfunction

    // Transaction-level reference model.
    int              m_ptr = 0;
    logic [NREQ-1:0] m_flag = '0;
    bit              pend = 1'b0;
    int              p_idx = 0, p_acc = 0, p_lat = 3, last_acc = -1;
    bit              p_skip = 1'b0;
    logic [3:0]      p_a, p_b, p_ctl, e_res;
    logic            p_cin, e_cry, e_zro, e_err;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy, exp_rv, oh;
        logic [3:0] r;
        logic c, ok;
        if (!rr_mode) last_acc = -1;
        if (reset) begin
            m_ptr  = 0;
            m_flag = '0;
            pend   = 1'b0;
        end else begin
            oh      = NREQ'(1) << p_idx;
            exp_rdy = pend ? '0 : rr_pick(req_valid, m_ptr);
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, pend);
            chk("alu_valid_in", alu_valid_in, pend && !p_skip && (cyc == p_acc + 1));
            if (pend && !p_skip && (cyc == p_acc + 1)) begin
                chk("alu_a", alu_a, p_a);
                chk("alu_b", alu_b, p_b);
                chk("alu_ctl", alu_ctl, p_ctl);
                chk("alu_cin", alu_cin, p_cin);
            end
            exp_rv = (pend && (cyc >= p_acc + p_lat)) ? oh : '0;
            chk("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv != '0) begin
                chk("rsp_alu", rsp_alu, e_res);
                chk("rsp_carry", rsp_carry, e_cry);
                chk("rsp_zero", rsp_zero, e_zro);
                chk("rsp_err", rsp_err, e_err);
                if ((exp_rv & rsp_ready) != '0) pend = 1'b0;
            end else if ((exp_rdy & req_valid) != '0) begin
                for (int k = 0; k < NREQ; k++) if (exp_rdy == (NREQ'(1) << k)) p_idx = k;
                oh     = NREQ'(1) << p_idx;
                p_a    = 4'(req_a >> (W * p_idx));
                p_b    = 4'(req_b >> (W * p_idx));
                p_ctl  = 4'(req_ctl >> (W * p_idx));
                p_cin  = (m_flag & oh) != '0;
                p_acc  = cyc;
                pend   = 1'b1;
                m_ptr  = (p_idx + 1) % NREQ;
                p_skip = OPCHK && (p_ctl > 4'd13);
                p_lat  = p_skip ? 1 : 3;
                alu_ref(p_ctl, p_a, p_b, p_cin, r, c, ok);
                if (ok && !p_skip) begin
                    e_res = r; e_cry = c; e_zro = (r == 4'h0); e_err = 1'b0;
                    if (p_ctl >= 4'd3 && p_ctl <= 4'd6) m_flag = c ? (m_flag | oh) : (m_flag & ~oh);
                end else begin
                    e_res = 4'h0; e_cry = 1'b0; e_zro = 1'b0; e_err = 1'b1;
                end
                if (last_acc >= 0) chk("rr_spacing", cyc - last_acc, 4);
                last_acc = cyc;
            end
        end
    end

    // Issue one operation from requester i and return the response fields.
    task automatic run_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic [3:0] ctl,
                          output logic [3:0] r, output logic c, output logic z, output logic e);
        int n;
        logic [NREQ-1:0] m;
        m = NREQ'(1) << i;
        @(posedge clk); #1;
        req_valid = m;
        req_a = {NREQ{a}}; req_b = {NREQ{b}}; req_ctl = {NREQ{ctl}};
        n = 0;
        do begin @(negedge clk); n++; end while (((req_ready & m) == '0) && n < 20);
        if (n >= 20) chk("grant_timeout", 1, 0);
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (((rsp_valid & m) == '0) && n < 20);
        if (n >= 20) chk("rsp_timeout", 1, 0);
        r = rsp_alu; c = rsp_carry; z = rsp_zero; e = rsp_err;
    endtask

    initial begin
        logic [3:0] r;
        logic c, z, e;
        int n;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_alu", rsp_alu, 0);
        chk("rst_rsp_carry", rsp_carry, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_valid_in", alu_valid_in, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_ctl", alu_ctl, 0);
        chk("rst_alu_cin", alu_cin, 0);

        run_op(0, 4'd9, 4'd8, 4'd3, r, c, z, e);
        chk("add_res", r, 4'd1); chk("add_carry", c, 1); chk("add_err", e, 0);
        run_op(0, 4'd1, 4'd1, 4'd4, r, c, z, e);
        chk("addc_res", r, 4'd3); chk("addc_carry", c, 0);

        run_op(1, 4'hF, 4'h1, 4'd3, r, c, z, e);
        chk("add1_res", r, 4'd0); chk("add1_zero", z, 1);
        run_op(1, 4'h2, 4'hF, 4'd1, r, c, z, e);
        chk("rej_err", e, 1); chk("rej_res", r, 4'd0);
        run_op(1, 4'h0, 4'h0, 4'd4, r, c, z, e);
        chk("flag_kept", r, 4'd1);

        run_op(0, 4'h3, 4'h3, 4'd15, r, c, z, e);
        chk("op15_err", e, 1); chk("op15_res", r, 4'd0);

        // Both requesters held valid: grants alternate every 4 cycles.
        @(posedge clk); #1;
        rr_mode = 1'b1;
        req_valid = '1; req_a = '0; req_b = '0; req_ctl = {NREQ{4'd8}};
        repeat (24) @(posedge clk);
        #1 req_valid = '0;
        repeat (6) @(posedge clk);
        #1 rr_mode = 1'b0;

        // Backpressure, then reset while the response is held.
        rsp_ready = '0;
        req_valid = 2'b01; req_a = {NREQ{4'd7}}; req_b = {NREQ{4'd9}}; req_ctl = {NREQ{4'd3}};
        n = 0;
        do begin @(negedge clk); n++; end while (((req_ready & 2'b01) == '0) && n < 20);
        if (n >= 20) chk("bp_grant_timeout", 1, 0);
        @(posedge clk); #1 req_valid = '1;
        n = 0;
        do begin @(negedge clk); n++; end while (((rsp_valid & 2'b01) == '0) && n < 20);
        if (n >= 20) chk("bp_rsp_timeout", 1, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 2'b01);
            chk("bp_rsp_alu", rsp_alu, 4'd0);
            chk("bp_rsp_carry", rsp_carry, 1);
        end
        @(posedge clk); #1;
        reset = 1'b1; req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0; rsp_ready = '1;
        @(negedge clk);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_busy", busy, 0);
        run_op(0, 4'h0, 4'h0, 4'd4, r, c, z, e);
        chk("post_rst_flag", r, 4'd0);

        // Randomized traffic with occasional backpressure and resets.
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            req_valid = NREQ'($urandom);
            req_a     = (W*NREQ)'($urandom);
            req_b     = (W*NREQ)'($urandom);
            req_ctl   = (W*NREQ)'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0) ? '1 : NREQ'($urandom);
            reset     = ($urandom_range(0, 149) == 0);
        end
        @(posedge clk); #1;
        req_valid = '0; rsp_ready = '1; reset = 1'b0;
        repeat (10) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
